// File: rtl/e203_exu_bjp_cmt_if.sv
// Commit interface between the branch/jump unit, CSR file, IFU and the
// BJP commit stage. Carries the commit handshake and instruction attributes,
// the CSR PC values, the IFU redirect channel, the CSR MRET/DRET pulses and
// the performance counter controls/values.
//   master : the BJP/CSR/IFU side (drives commit inputs, acks redirects)
//   slave  : the commit stage (e203_exu_bjp_cmt)
interface e203_exu_bjp_cmt_if #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 32
);
  logic               cmt_i_valid;
  logic               cmt_i_ready;
  logic               cmt_i_bjp;
  logic               cmt_i_mret;
  logic               cmt_i_dret;
  logic               cmt_i_fencei;
  logic               cmt_i_prdt;
  logic               cmt_i_rslv;
  logic               cmt_i_rv32;
  logic [PC_SIZE-1:0] cmt_i_pc;
  logic [PC_SIZE-1:0] cmt_i_imm;
  logic [PC_SIZE-1:0] csr_epc;
  logic [PC_SIZE-1:0] csr_dpc;
  logic               flush_req;
  logic [PC_SIZE-1:0] flush_pc;
  logic               flush_ack;
  logic               cmt_mret_ena;
  logic               cmt_dret_ena;
  logic               cnt_clr;
  logic [CNT_W-1:0]   bjp_cnt;
  logic [CNT_W-1:0]   mispred_cnt;

  modport master (
    output cmt_i_valid, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei,
           cmt_i_prdt, cmt_i_rslv, cmt_i_rv32, cmt_i_pc, cmt_i_imm,
           csr_epc, csr_dpc, flush_ack, cnt_clr,
    input  cmt_i_ready, flush_req, flush_pc, cmt_mret_ena, cmt_dret_ena,
           bjp_cnt, mispred_cnt
  );

  modport slave (
    input  cmt_i_valid, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei,
           cmt_i_prdt, cmt_i_rslv, cmt_i_rv32, cmt_i_pc, cmt_i_imm,
           csr_epc, csr_dpc, flush_ack, cnt_clr,
    output cmt_i_ready, flush_req, flush_pc, cmt_mret_ena, cmt_dret_ena,
           bjp_cnt, mispred_cnt
  );
endinterface

// File: rtl/e203_exu_bjp_cmt.sv
// BJP commit stage. Accepts branch-class instructions from the BJP unit,
// decides whether the pipeline must be flushed (mispredict, MRET, DRET,
// FENCE.I), computes the redirect target and holds a registered flush
// request towards the IFU until it is acknowledged. While a redirect is
// pending no further instruction is accepted. Also counts committed
// branches and mispredicts (wrap-around, synchronous clear).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : commit/CSR/IFU/counter signals (slave modport)
module e203_exu_bjp_cmt #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  e203_exu_bjp_cmt_if.slave    bus
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [PC_SIZE-1:0] flush_pc_q;
  logic               mret_ena_q, dret_ena_q;
  logic [CNT_W-1:0]   bjp_cnt_q, mispred_cnt_q;

  logic               accept;
  logic               mispred;
  logic               need_flush;
  logic [PC_SIZE-1:0] ilen;
  logic [PC_SIZE-1:0] target;

  assign bus.cmt_i_ready = (state == IDLE);
  assign accept          = bus.cmt_i_valid && bus.cmt_i_ready;
  assign mispred         = bus.cmt_i_bjp && (bus.cmt_i_prdt != bus.cmt_i_rslv);
  assign need_flush      = bus.cmt_i_dret | bus.cmt_i_mret | bus.cmt_i_fencei | mispred;
  assign ilen            = bus.cmt_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2);

  // Redirect target in priority order; adds wrap modulo 2^PC_SIZE.
  always_comb begin
    target = bus.cmt_i_pc + ilen;
    if (bus.cmt_i_dret)                 target = bus.csr_dpc;
    else if (bus.cmt_i_mret)            target = bus.csr_epc;
    else if (bus.cmt_i_fencei)          target = bus.cmt_i_pc + ilen;
    else if (mispred && bus.cmt_i_rslv) target = bus.cmt_i_pc + bus.cmt_i_imm;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && need_flush) state_nxt = FLUSH;
      FLUSH:   if (bus.flush_ack)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      flush_pc_q    <= '0;
      mret_ena_q    <= 1'b0;
      dret_ena_q    <= 1'b0;
      bjp_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state      <= state_nxt;
      mret_ena_q <= accept && bus.cmt_i_mret;
      dret_ena_q <= accept && bus.cmt_i_dret;
      // Target only loads on a flushing accept, so it stays stable in FLUSH.
      if (accept && need_flush)
        flush_pc_q <= target;
      if (bus.cnt_clr) begin
        bjp_cnt_q     <= '0;
        mispred_cnt_q <= '0;
      end else begin
        if (accept && bus.cmt_i_bjp) bjp_cnt_q     <= bjp_cnt_q + CNT_W'(1);
        if (accept && mispred)       mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  // The request is the state flop itself, so reset drops it immediately.
  assign bus.flush_req    = (state == FLUSH);
  assign bus.flush_pc     = flush_pc_q;
  assign bus.cmt_mret_ena = mret_ena_q;
  assign bus.cmt_dret_ena = dret_ena_q;
  assign bus.bjp_cnt      = bjp_cnt_q;
  assign bus.mispred_cnt  = mispred_cnt_q;

endmodule

// File: doc/e203_exu_bjp_cmt.md
Name: e203_exu_bjp_cmt

Overview:
- Commit-side consumer of the branch/jump unit's commit interface (valid/ready, bjp, mret, dret, fencei, prdt, rslv).
- Decides whether an accepted branch-class instruction needs a pipeline flush, computes the redirect target, and holds a registered flush request to the IFU until it is acknowledged.
- Also keeps wrap-around performance counters for committed branches and mispredicts.

Parameters:
- PC_SIZE, 32, width of PC, immediate, target and CSR PC inputs.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- cmt_i_valid  input  1  commit valid from BJP.
- cmt_i_ready  output  1  commit ready to BJP.
- cmt_i_bjp  input  1  instruction is a branch or jump.
- cmt_i_mret  input  1  instruction is MRET.
- cmt_i_dret  input  1  instruction is DRET.
- cmt_i_fencei  input  1  instruction is FENCE.I.
- cmt_i_prdt  input  1  IFU predicted taken.
- cmt_i_rslv  input  1  resolved taken.
- cmt_i_rv32  input  1  1 = 32-bit instruction, 0 = 16-bit.
- cmt_i_pc  input  PC_SIZE  instruction PC.
- cmt_i_imm  input  PC_SIZE  branch offset, sign-extended.
- csr_epc  input  PC_SIZE  mepc value.
- csr_dpc  input  PC_SIZE  dpc value.
- flush_req  output  1  redirect request to IFU.
- flush_pc  output  PC_SIZE  redirect target.
- flush_ack  input  1  IFU accepts the redirect.
- cmt_mret_ena  output  1  one-cycle pulse to CSR on MRET acceptance.
- cmt_dret_ena  output  1  one-cycle pulse to CSR on DRET acceptance.
- cnt_clr  input  1  synchronous clear of both counters.
- bjp_cnt  output  CNT_W  committed bjp instructions.
- mispred_cnt  output  CNT_W  committed mispredicts.

Behaviour:
- States: IDLE, FLUSH. Reset state IDLE.
- Reset values: flush_req=0, flush_pc=0, cmt_mret_ena=0, cmt_dret_ena=0, bjp_cnt=0, mispred_cnt=0.
- cmt_i_ready = (state==IDLE). An instruction is accepted when cmt_i_valid && cmt_i_ready.
- ilen = cmt_i_rv32 ? 4 : 2.
- mispred = cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv).
- need_flush = dret | mret | fencei | mispred.
- Target priority on acceptance:
  - dret → csr_dpc.
  - else mret → csr_epc.
  - else fencei → pc+ilen.
  - else mispred with rslv=1 → pc+imm.
  - else mispred with rslv=0 → pc+ilen.
- Target adds are modulo 2^PC_SIZE; carry is discarded.
- Accept with need_flush:
  - Register the target into flush_pc and move to FLUSH.
  - flush_req rises the next cycle, so latency is 1 cycle from acceptance to request.
- Accept without need_flush: stay in IDLE; no flush.
- FLUSH:
  - flush_req=1 and flush_pc is held stable until flush_ack is sampled high.
  - On ack: next cycle state=IDLE, flush_req=0, cmt_i_ready=1.
  - Ack in the same cycle flush_req first rises counts; the minimum FLUSH dwell is 1 cycle.
- flush_ack while in IDLE is ignored.
- cmt_mret_ena / cmt_dret_ena: registered pulse for exactly one cycle after MRET/DRET acceptance. Both pulse if both inputs are set; the target still follows the priority order above.
- Counters, updated on acceptance:
  - bjp_cnt += 1 when cmt_i_bjp.
  - mispred_cnt += 1 when mispred.
  - Both wrap from all-ones to 0.
  - cnt_clr takes priority over a same-cycle increment; result is 0.
- Asynchronous reset mid-FLUSH: immediately return to IDLE with flush_req=0; the pending redirect is dropped.

Test Plan:
- Correct prediction, no flush: pc=0x100, bjp=1, prdt=1, rslv=1 → accepted in one cycle; flush_req stays 0; bjp_cnt=1, mispred_cnt=0.
- Mispredict not-taken: pc=0x200, imm=0x40, rv32=1, prdt=0, rslv=1 → next cycle flush_req=1, flush_pc=0x240; cmt_i_ready=0 until ack. Ack after 3 cycles → flush_req drops next cycle; mispred_cnt=1.
- Mispredict taken, 16-bit instruction: pc=0x300, rv32=0, prdt=1, rslv=0 → flush_pc=0x302.
- MRET+DRET together: csr_epc=0x80, csr_dpc=0x800 → flush_pc=0x800; cmt_mret_ena and cmt_dret_ena each pulse for one cycle.
- Target wrap: pc=0xFFFFFFFC, fencei=1, rv32=1 → flush_pc=0x0. Then assert rst while in FLUSH → flush_req=0 and cmt_i_ready=1 immediately.
- Counter boundaries: preload mispred_cnt to 0xFFFFFFFF, commit one mispredict → mispred_cnt=0. Assert cnt_clr together with an increment → both counters=0.
